hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Parametrised pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MA/WB). It replaces the purely combinational forwarding selector, generalising forwarding to NUM_RD_PORTS operands with x0 exclusion and MA-load suppression. It adds a sequenced load-use stall, branch flush, data-memory wait freeze with timeout, and saturating performance counters. It sits beside the datapath and drives the forwarding muxes in EX and the hold/flush enables of the pipeline registers.

## Interface
Parameters:
- REG_AW, 5, register address width
- NUM_RD_PORTS, 2, forwarded source operands per instruction
- MA_LOAD_FWD, 0, 1 = load data may be forwarded from MA (load-use stall 1 cycle), 0 = suppressed (stall 2 cycles)
- MEM_TIMEOUT, 255, freeze cycles before mem_timeout sets; 0 disables
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- RS_ID  in  NUM_RD_PORTS*REG_AW  sources of instruction in ID, port k at bits [k*REG_AW +: REG_AW]
- RS_EX  in  NUM_RD_PORTS*REG_AW  sources of instruction in EX, same packing
- RD_EX, RD_MA, RD_WB  in  REG_AW each  destination registers per stage
- MemRd_EX, MemRd_MA  in  1 each  instruction in that stage is a load
- RegWEn_MA, RegWEn_WB  in  1 each  register write enable per stage
- PCSel_EX  in  1  taken branch/jump resolved in EX
- dmem_req_MA, dmem_ready  in  1 each  data-memory request in MA / memory ready
- cnt_clr  in  1  synchronous clear of performance counters
- hazardSel  out  NUM_RD_PORTS*2  per port: 00 regfile, 01 MA, 10 WB
- stall_IF  out  1  hold PC and IF/ID
- bubble_EX  out  1  load NOP into ID/EX
- flush_ID  out  1  load NOP into IF/ID
- freeze  out  1  hold every pipeline register
- mem_timeout  out  1  sticky error
- stall_cycles, flush_count  out  CNT_W each  saturating counters

## Operation
- Forwarding, per port k, first match wins:
  - 01 if RegWEn_MA & RD_MA!=0 & RD_MA==RS_EX[k] & (MA_LOAD_FWD | !MemRd_MA).
  - Else 10 if RegWEn_WB & RD_WB!=0 & RD_WB==RS_EX[k].
  - Else 00.
  - Ports are independent and may select different sources in the same cycle.
- freeze = dmem_req_MA & !dmem_ready.
  - While freeze=1: stall_IF, bubble_EX, flush_ID forced 0; FSM state and stall counter hold.
- Flush, when PCSel_EX & !freeze:
  - flush_ID=1, bubble_EX=1, stall_IF=0.
  - Overrides any load-use condition; FSM goes to RUN and the counter clears.
- Load-use hit = MemRd_EX & RD_EX!=0 & any RS_ID[k]==RD_EX.
- STALL_LEN = 1 if MA_LOAD_FWD else 2.
- FSM, states RUN and LOAD_STALL:
  - RUN with hit (no freeze, no flush): stall_IF=1, bubble_EX=1. If STALL_LEN=2, load ld_cnt=1 and go to LOAD_STALL; else stay in RUN.
  - LOAD_STALL: stall_IF=1, bubble_EX=1, ld_cnt decrements; go to RUN when ld_cnt reaches 0.
  - LOAD_STALL does not re-evaluate a hit.
- Timeout:
  - wait_cnt (width clog2(MEM_TIMEOUT+1)) increments each freeze cycle and clears when freeze=0.
  - When wait_cnt==MEM_TIMEOUT and freeze=1, mem_timeout sets and stays set until reset.
  - MEM_TIMEOUT=0 means mem_timeout is never set.
- Counters:
  - stall_cycles +1 on each cycle with stall_IF|freeze.
  - flush_count +1 on each cycle with flush_ID.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment; the counter reads 0 on the next cycle.

## Timing
- hazardSel, stall_IF, bubble_EX, flush_ID, freeze are combinational from the inputs and the registered state, valid in the same cycle; all are forced 0 while reset_n=0.
- State, ld_cnt, wait_cnt, mem_timeout and the counters update on the rising clk edge.
- reset_n low, asynchronous: state=RUN, ld_cnt=0, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_count=0, hazardSel=0.
- Reset during LOAD_STALL or freeze aborts immediately; the first cycle after release is RUN.
- Load-use total stall: 2 cycles (MA_LOAD_FWD=0) or 1 cycle (MA_LOAD_FWD=1), not counting freeze cycles inserted between them.
- Flush lasts exactly the cycle in which PCSel_EX is high and freeze is low.

## Test plan
- RS_EX={x5,x6}, RD_MA=x5, RD_WB=x6, both RegWEn=1 -> hazardSel={10,01} (port1=WB, port0=MA); RD_MA=RD_WB=x0 -> 00 on both ports.
- Load x7 in EX, RS_ID port0=x7, MA_LOAD_FWD=0 -> stall_IF=bubble_EX=1 for 2 cycles; in the second cycle MA forwarding is suppressed (MemRd_MA=1); the dependent instruction then gets hazardSel=10; stall_cycles=2.
- Same with MA_LOAD_FWD=1 -> 1 stall cycle, then hazardSel=01 from MA.
- dmem_req_MA=1, dmem_ready=0 for 3 cycles during LOAD_STALL -> freeze=1 and stall_IF=0 for those 3 cycles; LOAD_STALL resumes with 1 cycle left; stall_cycles increments by 4 total.
- PCSel_EX=1 with a load-use hit present -> flush_ID=bubble_EX=1, stall_IF=0, flush_count=1, state RUN.
- MEM_TIMEOUT=4, freeze held 10 cycles -> mem_timeout rises after cycle 5 and stays high after freeze drops; reset_n pulse clears it. Counter at all-ones with activity -> holds; cnt_clr -> 0.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Hazard controller bundle: datapath-side stage info in, forwarding selects,
// pipeline-register hold/flush controls and performance counters out.
interface hazard_control_unit_if #(
  parameter int REG_AW       = 5,
  parameter int NUM_RD_PORTS = 2,
  parameter int CNT_W        = 16
);
  logic [NUM_RD_PORTS*REG_AW-1:0] RS_ID;
  logic [NUM_RD_PORTS*REG_AW-1:0] RS_EX;
  logic [REG_AW-1:0]              RD_EX;
  logic [REG_AW-1:0]              RD_MA;
  logic [REG_AW-1:0]              RD_WB;
  logic                           MemRd_EX;
  logic                           MemRd_MA;
  logic                           RegWEn_MA;
  logic                           RegWEn_WB;
  logic                           PCSel_EX;
  logic                           dmem_req_MA;
  logic                           dmem_ready;
  logic                           cnt_clr;
  logic [NUM_RD_PORTS*2-1:0]      hazardSel;
  logic                           stall_IF;
  logic                           bubble_EX;
  logic                           flush_ID;
  logic                           freeze;
  logic                           mem_timeout;
  logic [CNT_W-1:0]               stall_cycles;
  logic [CNT_W-1:0]               flush_count;

  // datapath side
  modport master (
    output RS_ID, RS_EX, RD_EX, RD_MA, RD_WB, MemRd_EX, MemRd_MA,
           RegWEn_MA, RegWEn_WB, PCSel_EX, dmem_req_MA, dmem_ready, cnt_clr,
    input  hazardSel, stall_IF, bubble_EX, flush_ID, freeze, mem_timeout,
           stall_cycles, flush_count
  );

  // hazard controller side
  modport slave (
    input  RS_ID, RS_EX, RD_EX, RD_MA, RD_WB, MemRd_EX, MemRd_MA,
           RegWEn_MA, RegWEn_WB, PCSel_EX, dmem_req_MA, dmem_ready, cnt_clr,
    output hazardSel, stall_IF, bubble_EX, flush_ID, freeze, mem_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core: per-operand EX
// forwarding, load-use stall sequencing, branch flush, dmem wait freeze with
// timeout, and saturating stall/flush counters.

// One forwarding selector per source operand. MA beats WB (younger result).
module hazard_fwd_lane #(
  parameter int REG_AW      = 5,
  parameter int MA_LOAD_FWD = 0
) (
  input  logic              en,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_ma,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              regwen_ma,
  input  logic              regwen_wb,
  input  logic              memrd_ma,
  output logic [1:0]        sel
);
  logic ma_hit, wb_hit;

  // priority select; load data in MA only usable when the core allows it
  always_comb begin
    ma_hit = regwen_ma && (rd_ma != '0) && (rd_ma == rs) &&
             ((MA_LOAD_FWD != 0) || !memrd_ma);
    wb_hit = regwen_wb && (rd_wb != '0) && (rd_wb == rs);
    sel    = 2'b00;
    if (en) begin
      if (ma_hit)      sel = 2'b01;
      else if (wb_hit) sel = 2'b10;
    end
  end
endmodule

module hazard_control_unit #(
  parameter int REG_AW       = 5,
  parameter int NUM_RD_PORTS = 2,
  parameter int MA_LOAD_FWD  = 0,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  hazard_control_unit_if.slave hif
);
  localparam int STALL_LEN = (MA_LOAD_FWD != 0) ? 1 : 2;
  localparam int WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {RUN, LOAD_STALL} state_t;

  state_t                                 state_q, state_d;
  logic [1:0]                             ld_cnt_q, ld_cnt_d;
  logic [WAIT_W-1:0]                      wait_cnt_q;
  logic                                   mem_timeout_q;
  logic [CNT_W-1:0]                       stall_cnt_q, flush_cnt_q;
  logic [NUM_RD_PORTS-1:0][REG_AW-1:0]    rs_id, rs_ex;
  logic [NUM_RD_PORTS-1:0][1:0]           sel;
  logic                                   ld_hit, freeze;
  logic                                   stall_if, bubble_ex, flush_id;

  assign rs_id = hif.RS_ID;
  assign rs_ex = hif.RS_EX;

  // memory wait stalls the whole pipe; outputs are quiet while in reset
  assign freeze = reset_n && hif.dmem_req_MA && !hif.dmem_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_RD_PORTS; k++) begin : g_lane
      hazard_fwd_lane #(.REG_AW(REG_AW), .MA_LOAD_FWD(MA_LOAD_FWD)) u_lane (
        .en        (reset_n),
        .rs        (rs_ex[k]),
        .rd_ma     (hif.RD_MA),
        .rd_wb     (hif.RD_WB),
        .regwen_ma (hif.RegWEn_MA),
        .regwen_wb (hif.RegWEn_WB),
        .memrd_ma  (hif.MemRd_MA),
        .sel       (sel[k])
      );
    end
  endgenerate

  // load in EX whose destination feeds any operand of the ID instruction
  always_comb begin
    ld_hit = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++)
      if (rs_id[p] == hif.RD_EX) ld_hit = 1'b1;
    ld_hit = ld_hit && hif.MemRd_EX && (hif.RD_EX != '0);
  end

  // next state and stall/flush controls; freeze holds everything, flush wins over stall
  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (reset_n && !freeze) begin
      if (hif.PCSel_EX) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = RUN;
        ld_cnt_d  = '0;
      end else begin
        case (state_q)
          RUN: begin
            if (ld_hit) begin
              stall_if  = 1'b1;
              bubble_ex = 1'b1;
              if (STALL_LEN > 1) begin
                ld_cnt_d = 2'(STALL_LEN - 1);
                state_d  = LOAD_STALL;
              end
            end
          end
          LOAD_STALL: begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
            if (ld_cnt_q <= 2'd1) begin
              ld_cnt_d = '0;
              state_d  = RUN;
            end else begin
              ld_cnt_d = ld_cnt_q - 2'd1;
            end
          end
          default: begin
            state_d  = RUN;
            ld_cnt_d = '0;
          end
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // freeze length tracking; the timeout flag is sticky until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (!freeze)
        wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT))
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      if ((MEM_TIMEOUT != 0) && freeze && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)))
        mem_timeout_q <= 1'b1;
    end
  end

  // saturating performance counters, clear beats increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (hif.cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall_if || freeze) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_id && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hif.hazardSel    = sel;
  assign hif.stall_IF     = stall_if;
  assign hif.bubble_EX    = bubble_ex;
  assign hif.flush_ID     = flush_id;
  assign hif.freeze       = freeze;
  assign hif.mem_timeout  = mem_timeout_q;
  assign hif.stall_cycles = stall_cnt_q;
  assign hif.flush_count  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: dut_a (MA load forwarding off, timeout 4, 16-bit counters)
// and dut_b (MA load forwarding on, timeout off, 3-bit counters) share stimulus.
module tb_hazard_control_unit;
  localparam int AW = 5;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NP*AW-1:0] rs_id, rs_ex;
  logic [AW-1:0]    rd_ex, rd_ma, rd_wb;
  logic memrd_ex, memrd_ma, we_ma, we_wb, pcsel, dreq, drdy, cnt_clr;

  int checks   = 0;
  int failures = 0;

  hazard_control_unit_if #(.REG_AW(AW), .NUM_RD_PORTS(NP), .CNT_W(16)) ifa ();
  hazard_control_unit_if #(.REG_AW(AW), .NUM_RD_PORTS(NP), .CNT_W(3))  ifb ();

  assign ifa.RS_ID = rs_id;       assign ifb.RS_ID = rs_id;
  assign ifa.RS_EX = rs_ex;       assign ifb.RS_EX = rs_ex;
  assign ifa.RD_EX = rd_ex;       assign ifb.RD_EX = rd_ex;
  assign ifa.RD_MA = rd_ma;       assign ifb.RD_MA = rd_ma;
  assign ifa.RD_WB = rd_wb;       assign ifb.RD_WB = rd_wb;
  assign ifa.MemRd_EX = memrd_ex; assign ifb.MemRd_EX = memrd_ex;
  assign ifa.MemRd_MA = memrd_ma; assign ifb.MemRd_MA = memrd_ma;
  assign ifa.RegWEn_MA = we_ma;   assign ifb.RegWEn_MA = we_ma;
  assign ifa.RegWEn_WB = we_wb;   assign ifb.RegWEn_WB = we_wb;
  assign ifa.PCSel_EX = pcsel;    assign ifb.PCSel_EX = pcsel;
  assign ifa.dmem_req_MA = dreq;  assign ifb.dmem_req_MA = dreq;
  assign ifa.dmem_ready = drdy;   assign ifb.dmem_ready = drdy;
  assign ifa.cnt_clr = cnt_clr;   assign ifb.cnt_clr = cnt_clr;

  hazard_control_unit #(.REG_AW(AW), .NUM_RD_PORTS(NP), .MA_LOAD_FWD(0),
                        .MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .hif(ifa));
  hazard_control_unit #(.REG_AW(AW), .NUM_RD_PORTS(NP), .MA_LOAD_FWD(1),
                        .MEM_TIMEOUT(0), .CNT_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .hif(ifb));

  typedef struct {
    logic [NP*AW-1:0] rs_ex;
    logic [AW-1:0]    rd_ma, rd_wb;
    logic             we_ma, we_wb, ld_ma;
    logic [3:0]       exp_a, exp_b;
  } fwd_vec_t;

  fwd_vec_t vecs [9];

  function automatic fwd_vec_t mk(input logic [4:0] p1, input logic [4:0] p0,
                                  input logic [4:0] ma, input logic [4:0] wb,
                                  input logic wm, input logic ww, input logic lm,
                                  input logic [3:0] ea, input logic [3:0] eb);
    fwd_vec_t v;
    v.rs_ex = {p1, p0}; v.rd_ma = ma; v.rd_wb = wb;
    v.we_ma = wm; v.we_wb = ww; v.ld_ma = lm; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs_id = '0; rs_ex = '0; rd_ex = '0; rd_ma = '0; rd_wb = '0;
    memrd_ex = 1'b0; memrd_ma = 1'b0; we_ma = 1'b0; we_wb = 1'b0;
    pcsel = 1'b0; dreq = 1'b0; drdy = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // load x7 in EX hitting an ID operand
  task automatic load_hit(input logic [NP*AW-1:0] src);
    idle();
    memrd_ex = 1'b1; rd_ex = 5'd7; rs_id = src;
  endtask

  int base;

  initial begin
    // hazardSel per port: {port1, port0}, 01 = MA, 10 = WB
    vecs[0] = mk(5'd6,  5'd5, 5'd5,  5'd6,  1, 1, 0, 4'b1001, 4'b1001);
    vecs[1] = mk(5'd6,  5'd5, 5'd0,  5'd0,  1, 1, 0, 4'b0000, 4'b0000);
    vecs[2] = mk(5'd0,  5'd0, 5'd0,  5'd0,  1, 1, 0, 4'b0000, 4'b0000);
    vecs[3] = mk(5'd5,  5'd5, 5'd5,  5'd5,  1, 1, 0, 4'b0101, 4'b0101);
    vecs[4] = mk(5'd5,  5'd5, 5'd5,  5'd5,  0, 1, 0, 4'b1010, 4'b1010);
    vecs[5] = mk(5'd5,  5'd5, 5'd5,  5'd5,  1, 1, 1, 4'b1010, 4'b0101);
    vecs[6] = mk(5'd7,  5'd3, 5'd3,  5'd9,  1, 1, 1, 4'b0000, 4'b0001);
    vecs[7] = mk(5'd9,  5'd3, 5'd3,  5'd9,  1, 0, 0, 4'b0001, 4'b0001);
    vecs[8] = mk(5'd31, 5'd31, 5'd30, 5'd31, 1, 1, 0, 4'b1010, 4'b1010);

    // ---- reset: outputs forced quiet even with live hazards on the inputs
    reset_n = 1'b1;
    idle();
    #1 reset_n = 1'b0;
    rs_ex = {5'd6, 5'd5}; rd_ma = 5'd5; we_ma = 1'b1;
    load_hit({5'd0, 5'd7}); rs_ex = {5'd6, 5'd5}; rd_ma = 5'd5; we_ma = 1'b1;
    dreq = 1'b1; drdy = 1'b0;
    settle();
    chk("rst_sel",     ifa.hazardSel, 4'b0000);
    chk("rst_stall",   ifa.stall_IF, 1'b0);
    chk("rst_bubble",  ifa.bubble_EX, 1'b0);
    chk("rst_freeze",  ifa.freeze, 1'b0);
    chk("rst_timeout", ifa.mem_timeout, 1'b0);
    chk("rst_scnt",    ifa.stall_cycles, 16'd0);
    chk("rst_fcnt",    ifa.flush_count, 16'd0);
    tick();
    idle();
    reset_n = 1'b1;
    settle();
    chk("post_rst_scnt", ifa.stall_cycles, 16'd0);

    // ---- forwarding table
    for (int i = 0; i < 9; i++) begin
      idle();
      rs_ex = vecs[i].rs_ex; rd_ma = vecs[i].rd_ma; rd_wb = vecs[i].rd_wb;
      we_ma = vecs[i].we_ma; we_wb = vecs[i].we_wb; memrd_ma = vecs[i].ld_ma;
      settle();
      chk($sformatf("fwd_a[%0d]", i), ifa.hazardSel, vecs[i].exp_a);
      chk($sformatf("fwd_b[%0d]", i), ifb.hazardSel, vecs[i].exp_b);
      chk($sformatf("fwd_stall[%0d]", i), ifa.stall_IF, 1'b0);
      tick();
    end

    // ---- load-use: a stalls 2 cycles, b stalls 1
    idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    settle();
    chk("clr_scnt", ifa.stall_cycles, 16'd0);
    load_hit({5'd0, 5'd7});
    settle();
    chk("lu1_stall_a",  ifa.stall_IF, 1'b1);
    chk("lu1_bubble_a", ifa.bubble_EX, 1'b1);
    chk("lu1_stall_b",  ifb.stall_IF, 1'b1);
    tick();
    idle(); rs_id = {5'd0, 5'd7}; memrd_ma = 1'b1; we_ma = 1'b1; rd_ma = 5'd7;
    rs_ex = {5'd0, 5'd7};
    settle();
    chk("lu2_stall_a",  ifa.stall_IF, 1'b1);
    chk("lu2_bubble_a", ifa.bubble_EX, 1'b1);
    chk("lu2_stall_b",  ifb.stall_IF, 1'b0);
    chk("lu2_sel_a",    ifa.hazardSel, 4'b0000);
    chk("lu2_sel_b",    ifb.hazardSel, 4'b0001);
    tick();
    idle(); we_wb = 1'b1; rd_wb = 5'd7; rs_ex = {5'd0, 5'd7};
    settle();
    chk("lu3_stall_a", ifa.stall_IF, 1'b0);
    chk("lu3_sel_a",   ifa.hazardSel, 4'b0010);
    chk("lu3_scnt_a",  ifa.stall_cycles, 16'd2);
    chk("lu3_scnt_b",  ifb.stall_cycles, 3'd1);
    tick();

    // ---- freeze in the middle of LOAD_STALL
    load_hit({5'd7, 5'd0});
    tick();
    base = int'(ifa.stall_cycles);
    for (int i = 0; i < 3; i++) begin
      idle(); dreq = 1'b1; drdy = 1'b0;
      settle();
      chk($sformatf("frz_freeze[%0d]", i), ifa.freeze, 1'b1);
      chk($sformatf("frz_stall[%0d]", i),  ifa.stall_IF, 1'b0);
      chk($sformatf("frz_bubble[%0d]", i), ifa.bubble_EX, 1'b0);
      tick();
    end
    idle(); dreq = 1'b1; drdy = 1'b1;
    settle();
    chk("frz_resume_stall", ifa.stall_IF, 1'b1);
    chk("frz_resume_frz",   ifa.freeze, 1'b0);
    tick();
    idle();
    settle();
    chk("frz_done_stall", ifa.stall_IF, 1'b0);
    chk("frz_scnt_delta", 32'(int'(ifa.stall_cycles) - base), 32'd4);
    tick();

    // ---- branch flush
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    settle();
    chk("clr_fcnt", ifa.flush_count, 16'd0);
    load_hit({5'd0, 5'd7}); pcsel = 1'b1;
    settle();
    chk("fl_flush",  ifa.flush_ID, 1'b1);
    chk("fl_bubble", ifa.bubble_EX, 1'b1);
    chk("fl_stall",  ifa.stall_IF, 1'b0);
    tick();
    idle();
    settle();
    chk("fl_after_flush", ifa.flush_ID, 1'b0);
    chk("fl_after_stall", ifa.stall_IF, 1'b0);
    chk("fl_fcnt_a",      ifa.flush_count, 16'd1);
    chk("fl_fcnt_b",      ifb.flush_count, 3'd1);
    chk("fl_scnt_a",      ifa.stall_cycles, 16'd0);
    tick();
    load_hit({5'd0, 5'd7});
    tick();
    idle(); pcsel = 1'b1;
    settle();
    chk("fl_ls_flush", ifa.flush_ID, 1'b1);
    chk("fl_ls_stall", ifa.stall_IF, 1'b0);
    tick();
    idle();
    settle();
    chk("fl_ls_run", ifa.stall_IF, 1'b0);
    tick();
    idle(); pcsel = 1'b1; dreq = 1'b1; drdy = 1'b0;
    settle();
    chk("fl_frz_flush",  ifa.flush_ID, 1'b0);
    chk("fl_frz_freeze", ifa.freeze, 1'b1);
    tick();
    idle();
    settle();
    chk("fl_frz_fcnt", ifa.flush_count, 16'd2);
    tick();

    // ---- timeout: limit 4, flag readable from the 6th freeze cycle on
    for (int i = 1; i <= 10; i++) begin
      idle(); dreq = 1'b1; drdy = 1'b0;
      settle();
      chk($sformatf("to_a[%0d]", i), ifa.mem_timeout, (i >= 6) ? 1'b1 : 1'b0);
      tick();
    end
    idle();
    settle();
    chk("to_sticky_a", ifa.mem_timeout, 1'b1);
    chk("to_off_b",    ifb.mem_timeout, 1'b0);
    load_hit({5'd0, 5'd7});
    tick();
    idle(); rs_id = {5'd0, 5'd7};
    settle();
    chk("rst2_pre_stall", ifa.stall_IF, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst2_timeout", ifa.mem_timeout, 1'b0);
    chk("rst2_stall",   ifa.stall_IF, 1'b0);
    tick();
    idle();
    reset_n = 1'b1;
    settle();
    chk("rst2_run", ifa.stall_IF, 1'b0);
    tick();
    settle();
    chk("rst2_run2", ifa.stall_IF, 1'b0);
    tick();

    // ---- counter saturation on the 3-bit instance
    for (int i = 0; i < 9; i++) begin
      idle(); dreq = 1'b1; drdy = 1'b0;
      tick();
    end
    settle();
    chk("sat_scnt_b", ifb.stall_cycles, 3'd7);
    chk("sat_scnt_a", ifa.stall_cycles, 16'd9);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    settle();
    chk("sat_clr_b", ifb.stall_cycles, 3'd0);
    for (int i = 0; i < 9; i++) begin
      idle(); pcsel = 1'b1;
      tick();
    end
    idle();
    settle();
    chk("sat_fcnt_b", ifb.flush_count, 3'd7);
    chk("sat_fcnt_a", ifa.flush_count, 16'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
